// File: rtl/min_max_array_loader_pkg.sv
// Shared sizing and one-hot state encoding for the min/max array loader.
// Imported by the loader top level and its register-file sub-module.
package min_max_array_loader_pkg;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int AW = 4;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [3:0] {
    FILL  = 4'b0001,
    START = 4'b0010,
    WAIT  = 4'b0100,
    HOLD  = 4'b1000
  } state_t;

endpackage

// File: rtl/min_max_array_loader_regfile.sv
// N x W element store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the loader always refills before use.
module min_max_array_loader_regfile
  import min_max_array_loader_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [N];

  // Element write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/min_max_array_loader.sv
// Fills the element array from a valid/ready stream, kicks the finder with Start,
// then captures and holds its Max/Min until the consumer acknowledges.
module min_max_array_loader
  import min_max_array_loader_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic [W-1:0]  Din,
  input  logic          Din_Valid,
  output logic          Din_Ready,
  input  logic [AW-1:0] Rd_Addr,
  output logic [W-1:0]  Rd_Data,
  output logic          Start,
  input  logic          Done,
  input  logic [W-1:0]  Max_In,
  input  logic [W-1:0]  Min_In,
  output logic [W-1:0]  Res_Max,
  output logic [W-1:0]  Res_Min,
  output logic          Res_Valid,
  input  logic          Res_Ack,
  output logic          Qf,
  output logic          Qs,
  output logic          Qw,
  output logic          Qh
);

  state_t        state_r;
  state_t        next_state_s;
  logic [AW-1:0] wr_ptr_r;
  logic [W-1:0]  res_max_r;
  logic [W-1:0]  res_min_r;
  logic          accept_s;
  logic          capture_s;

  // Writes and captures are gated by the registered state so stray inputs are inert.
  assign accept_s  = (state_r == FILL) && Din_Valid;
  assign capture_s = (state_r == WAIT) && Done;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= FILL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; any non-one-hot value recovers to FILL
  always_comb begin
    next_state_s = FILL;
    case (state_r)
      FILL: begin
        if (accept_s && (wr_ptr_r == LAST_IDX)) begin
          next_state_s = START;
        end else begin
          next_state_s = FILL;
        end
      end
      START: next_state_s = WAIT;
      WAIT: begin
        if (Done) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = WAIT;
        end
      end
      HOLD: begin
        if (Res_Ack) begin
          next_state_s = FILL;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = FILL;
    endcase
  end

  // Write pointer; the AW-bit wrap returns it to 0 after the last element
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r <= '0;
    end else if (accept_s) begin
      wr_ptr_r <= wr_ptr_r + AW'(1);
    end
  end

  // Result capture, held until the next capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      res_max_r <= '0;
      res_min_r <= '0;
    end else if (capture_s) begin
      res_max_r <= Max_In;
      res_min_r <= Min_In;
    end
  end

  min_max_array_loader_regfile u_regfile (
    .clk   (Clk),
    .we    (accept_s),
    .waddr (wr_ptr_r),
    .wdata (Din),
    .raddr (Rd_Addr),
    .rdata (Rd_Data)
  );

  assign Qf        = (state_r == FILL);
  assign Qs        = (state_r == START);
  assign Qw        = (state_r == WAIT);
  assign Qh        = (state_r == HOLD);
  assign Din_Ready = Qf;
  assign Start     = Qs;
  assign Res_Valid = Qh;
  assign Res_Max   = res_max_r;
  assign Res_Min   = res_min_r;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Directed bench for min_max_array_loader; the bench itself plays the finder.
module tb_min_max_array_loader;

  logic       Clk = 1'b0;
  logic       Reset, Din_Valid, Din_Ready, Start, Done, Res_Valid, Res_Ack;
  logic       Qf, Qs, Qw, Qh;
  logic [7:0] Din, Rd_Data, Max_In, Min_In, Res_Max, Res_Min;
  logic [3:0] Rd_Addr;

  logic [7:0] pat [16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_start;

  always #5 Clk = ~Clk;

  min_max_array_loader dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Din_Valid(Din_Valid), .Din_Ready(Din_Ready),
    .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Start(Start), .Done(Done),
    .Max_In(Max_In), .Min_In(Min_In), .Res_Max(Res_Max), .Res_Min(Res_Min),
    .Res_Valid(Res_Valid), .Res_Ack(Res_Ack), .Qf(Qf), .Qs(Qs), .Qw(Qw), .Qh(Qh)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are observed at negedge too.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Din_Valid = 1'b0; Done = 1'b0; Res_Ack = 1'b0;
    tick();
    Reset = 1'b0;
    check_eq("rst_state", {Qh, Qw, Qs, Qf}, 32'h1);
    check_eq("rst_ready", Din_Ready, 32'h1);
    check_eq("rst_start", Start, 32'h0);
    check_eq("rst_valid", Res_Valid, 32'h0);
    check_eq("rst_res", {Res_Max, Res_Min}, 32'h0);
  endtask

  task automatic set_inc(input logic [7:0] base);
    for (int i = 0; i < 16; i++) pat[i] = base + 8'(i);
  endtask

  task automatic set_const(input logic [7:0] v);
    for (int i = 0; i < 16; i++) pat[i] = v;
  endtask

  // Stream pat[] in; Start must appear exactly one cycle after the 16th accept.
  task automatic fill(input bit gapped);
    n_start = 0;
    for (int i = 0; i < 16; i++) begin
      if (gapped) begin
        Din_Valid = 1'b0; Din = 8'hEE;
        tick();
        if (Start) n_start++;
      end
      Din = pat[i]; Din_Valid = 1'b1;
      if (!Din_Ready) check_eq("fill_ready", Din_Ready, 32'h1);
      tick();
      if (i < 15 && Start) n_start++;
    end
    Din_Valid = 1'b0;
    check_eq("start_pulse", Start, 32'h1);
    check_eq("start_ready", Din_Ready, 32'h0);
    check_eq("early_start", n_start, 32'h0);
    tick();
    check_eq("start_once", Start, 32'h0);
    check_eq("wait_state", {Qh, Qw, Qs, Qf}, 32'h4);
    check_eq("wait_ready", Din_Ready, 32'h0);
  endtask

  task automatic verify_array(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      Rd_Addr = 4'(i); #1;
      if (Rd_Data !== pat[i]) begin
        bad++;
        check_eq(tag, Rd_Data, pat[i]);
      end
    end
    if (bad == 0) check_eq(tag, Rd_Data, pat[15]);
  endtask

  // Finder stand-in: scan the array through Rd_Addr, then report on Done.
  task automatic run_finder(input logic [7:0] emax, input logic [7:0] emin);
    logic [7:0] mx, mn;
    mx = 8'h00; mn = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      Rd_Addr = 4'(i); #1;
      if (Rd_Data > mx) mx = Rd_Data;
      if (Rd_Data < mn) mn = Rd_Data;
    end
    tick();
    check_eq("still_wait", Qw, 32'h1);
    Done = 1'b1; Max_In = mx; Min_In = mn;
    tick();
    Done = 1'b0; Max_In = 8'h00; Min_In = 8'h00;
    check_eq("hold_state", {Qh, Qw, Qs, Qf}, 32'h8);
    check_eq("res_valid", Res_Valid, 32'h1);
    check_eq("res_max", Res_Max, {24'h0, emax});
    check_eq("res_min", Res_Min, {24'h0, emin});
  endtask

  task automatic ack();
    tick();
    check_eq("valid_held", Res_Valid, 32'h1);
    Res_Ack = 1'b1;
    tick();
    Res_Ack = 1'b0;
    check_eq("ack_fill", {Qh, Qw, Qs, Qf}, 32'h1);
    check_eq("ack_valid_low", Res_Valid, 32'h0);
    check_eq("ack_ready", Din_Ready, 32'h1);
  endtask

  initial begin
    Reset = 1'b0; Din = 8'h00; Din_Valid = 1'b0; Rd_Addr = 4'h0;
    Done = 1'b0; Max_In = 8'h00; Min_In = 8'h00; Res_Ack = 1'b0;
    @(negedge Clk);
    do_reset();

    // 1: back-to-back fill
    set_inc(8'h10);
    fill(1'b0);
    verify_array("t1_array");
    run_finder(8'h1F, 8'h10);
    ack();

    // 2: gapped fill of the same data
    set_inc(8'h10);
    fill(1'b1);
    Rd_Addr = 4'd5; #1;
    check_eq("t2_rd5", Rd_Data, 32'h15);
    verify_array("t2_array");
    run_finder(8'h1F, 8'h10);
    ack();

    // 3 and 4: loopback with stray inputs in WAIT/HOLD
    pat = '{8'h80, 8'h03, 8'hFE, 8'h00, 8'h41, 8'h7F, 8'h22, 8'h10,
            8'h99, 8'h05, 8'hC3, 8'h64, 8'h01, 8'hFD, 8'h37, 8'h88};
    fill(1'b0);
    Din = 8'hA5; Din_Valid = 1'b1; Res_Ack = 1'b1;
    tick();
    Din_Valid = 1'b0; Res_Ack = 1'b0;
    check_eq("t4_wait_stay", Qw, 32'h1);
    verify_array("t4_wait_nowrite");
    run_finder(8'hFE, 8'h00);
    Din = 8'h5A; Din_Valid = 1'b1; Done = 1'b1; Max_In = 8'h11; Min_In = 8'h22;
    tick();
    Din_Valid = 1'b0; Done = 1'b0;
    check_eq("t4_hold_stay", Qh, 32'h1);
    check_eq("t4_hold_res", {Res_Max, Res_Min}, 32'hFE00);
    verify_array("t4_hold_nowrite");
    ack();
    Done = 1'b1; Max_In = 8'hAA; Min_In = 8'hBB;
    tick();
    Done = 1'b0;
    check_eq("t4_fill_done_res", {Res_Max, Res_Min}, 32'hFE00);
    check_eq("t4_fill_done_state", Qf, 32'h1);

    // 5: reset after a partial fill
    n_start = 0;
    for (int i = 0; i < 7; i++) begin
      Din = 8'hF0 + 8'(i); Din_Valid = 1'b1;
      tick();
      if (Start) n_start++;
    end
    Din_Valid = 1'b0;
    check_eq("t5_no_start", n_start, 32'h0);
    do_reset();
    pat = '{8'h33, 8'h9A, 8'h47, 8'h12, 8'hE0, 8'h5B, 8'h21, 8'h08,
            8'h76, 8'hBC, 8'h3D, 8'h61, 8'h0F, 8'hD4, 8'h2A, 8'h90};
    fill(1'b0);
    verify_array("t5_array");
    run_finder(8'hE0, 8'h08);
    ack();

    // 6: two back-to-back passes
    set_const(8'h55);
    fill(1'b0);
    run_finder(8'h55, 8'h55);
    ack();
    set_inc(8'h00);
    fill(1'b0);
    verify_array("t6_array");
    run_finder(8'h0F, 8'h00);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
